// File: rtl/fetch_trace_queue_pkg.sv
// Shared constants and entry layout for the fetch trace queue.
// The per-entry canceled flag is kept outside the entry RAM so that a flush can set every flag in one cycle.
package fetch_trace_queue_pkg;

  localparam int FTQ_DEPTH     = 4;
  localparam int FTQ_VADDR_W   = 32;
  localparam int FTQ_INST_NUM  = 4;
  localparam int FTQ_EXC_W     = 5;
  localparam int FTQ_PAYLOAD_W = 256;

  // RAM entry layout, LSB first: noreq, refill, exc, code, enable, vaddr, payload
  localparam int FTQ_OFF_NOREQ  = 0;
  localparam int FTQ_OFF_REFILL = 1;
  localparam int FTQ_OFF_EXC    = 2;
  localparam int FTQ_OFF_CODE   = 3;

  function automatic int ftqOffEnable(input int excW);
    return FTQ_OFF_CODE + excW;
  endfunction

  function automatic int ftqOffVaddr(input int excW, input int instNum);
    return ftqOffEnable(excW) + instNum;
  endfunction

  function automatic int ftqOffPayload(input int excW, input int instNum, input int vaddrW);
    return ftqOffVaddr(excW, instNum) + vaddrW;
  endfunction

  function automatic int ftqEntryW(input int excW, input int instNum, input int vaddrW,
                                   input int payloadW);
    return ftqOffPayload(excW, instNum, vaddrW) + payloadW;
  endfunction

endpackage

// File: rtl/fetch_trace_queue_if.sv
// Bundle of the fetch trace queue's upstream, MMU, bus-response and instruction-buffer signals.
interface fetch_trace_queue_if import fetch_trace_queue_pkg::*; #(
  parameter int DEPTH     = FTQ_DEPTH,
  parameter int VADDR_W   = FTQ_VADDR_W,
  parameter int INST_NUM  = FTQ_INST_NUM,
  parameter int EXC_W     = FTQ_EXC_W,
  parameter int PAYLOAD_W = FTQ_PAYLOAD_W
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                 in_valid;
  logic                 in_allowin;
  logic [VADDR_W-1:0]   in_vaddr;
  logic [INST_NUM-1:0]  in_enable;
  logic                 in_has_exc;
  logic [EXC_W-1:0]     in_exc_code;
  logic                 in_canceled;
  logic [PAYLOAD_W-1:0] in_payload;
  logic                 mmu_has_exc;
  logic [EXC_W-1:0]     mmu_exc_code;
  logic                 mmu_is_refill;
  logic                 inst_data_ok;
  logic                 flush;
  logic                 out_valid;
  logic [VADDR_W-1:0]   out_vaddr;
  logic [INST_NUM-1:0]  out_enable;
  logic                 out_has_exc;
  logic [EXC_W-1:0]     out_exc_code;
  logic                 out_is_refill;
  logic                 out_canceled;
  logic [PAYLOAD_W-1:0] out_payload;
  logic [CNT_W-1:0]     count;
  logic                 err_o;

  modport master (
    output in_valid, in_vaddr, in_enable, in_has_exc, in_exc_code, in_canceled, in_payload,
           mmu_has_exc, mmu_exc_code, mmu_is_refill, inst_data_ok, flush,
    input  in_allowin, out_valid, out_vaddr, out_enable, out_has_exc, out_exc_code,
           out_is_refill, out_canceled, out_payload, count, err_o
  );

  modport slave (
    input  in_valid, in_vaddr, in_enable, in_has_exc, in_exc_code, in_canceled, in_payload,
           mmu_has_exc, mmu_exc_code, mmu_is_refill, inst_data_ok, flush,
    output in_allowin, out_valid, out_vaddr, out_enable, out_has_exc, out_exc_code,
           out_is_refill, out_canceled, out_payload, count, err_o
  );

endinterface

// File: rtl/fetch_trace_queue_entry_ram.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module ftq_entry_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [PTR_W-1:0] i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_trace_queue.sv
// In-order queue of outstanding instruction-fetch requests between address translation and the
// instruction buffer; the head retires on inst_data_ok, or at once when no bus request was issued.
module fetch_trace_queue import fetch_trace_queue_pkg::*; #(
  parameter int DEPTH     = FTQ_DEPTH,
  parameter int VADDR_W   = FTQ_VADDR_W,
  parameter int INST_NUM  = FTQ_INST_NUM,
  parameter int EXC_W     = FTQ_EXC_W,
  parameter int PAYLOAD_W = FTQ_PAYLOAD_W
) (
  input logic clk,
  input logic rst,
  fetch_trace_queue_if.slave bus
);

  localparam int PTR_W       = $clog2(DEPTH);
  localparam int CNT_W       = PTR_W + 1;
  localparam int ENTRY_W     = ftqEntryW(EXC_W, INST_NUM, VADDR_W, PAYLOAD_W);
  localparam int OFF_ENABLE  = ftqOffEnable(EXC_W);
  localparam int OFF_VADDR   = ftqOffVaddr(EXC_W, INST_NUM);
  localparam int OFF_PAYLOAD = ftqOffPayload(EXC_W, INST_NUM, VADDR_W);

  logic [PTR_W-1:0]   r_wrPtr;
  logic [PTR_W-1:0]   r_rdPtr;
  logic [CNT_W-1:0]   r_count;
  logic [DEPTH-1:0]   r_canceled;
  logic               r_err;
  logic [DEPTH-1:0]   w_canceledNext;
  logic [ENTRY_W-1:0] w_wrEntry;
  logic [ENTRY_W-1:0] w_headEntry;
  logic               w_headValid;
  logic               w_headNoreq;
  logic               w_pop;
  logic               w_push;
  logic               w_allowin;
  logic               w_hasExc;
  logic [EXC_W-1:0]   w_excCode;
  logic               w_isRefill;
  logic               w_badDataOk;

  assign w_headValid = (r_count != '0);
  assign w_headNoreq = w_headEntry[FTQ_OFF_NOREQ];
  assign w_pop       = w_headValid && (bus.inst_data_ok || w_headNoreq);
  assign w_allowin   = (r_count != CNT_W'(DEPTH)) || w_pop;
  assign w_push      = bus.in_valid && w_allowin;
  assign w_badDataOk = bus.inst_data_ok && (!w_headValid || w_headNoreq);

  // Upstream exceptions outrank the MMU; an excepting group never issues a bus request
  assign w_hasExc   = bus.in_has_exc | bus.mmu_has_exc;
  assign w_excCode  = bus.in_has_exc ? bus.in_exc_code : bus.mmu_exc_code;
  assign w_isRefill = !bus.in_has_exc && bus.mmu_is_refill;
  assign w_wrEntry  = {bus.in_payload, bus.in_vaddr, bus.in_enable, w_excCode, w_hasExc,
                       w_isRefill, w_hasExc};

  ftq_entry_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_entryRam (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wrPtr),
    .i_wdata (w_wrEntry),
    .i_raddr (r_rdPtr),
    .o_rdata (w_headEntry)
  );

  // Flush marks every slot; the slot being pushed then takes its own flag, which includes flush
  always_comb begin
    w_canceledNext = r_canceled;
    if (bus.flush) w_canceledNext = '1;
    if (w_push) w_canceledNext[r_wrPtr] = bus.in_canceled | bus.flush;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_canceled <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pop) r_rdPtr <= r_rdPtr + PTR_W'(1);
      r_count    <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      r_canceled <= w_canceledNext;
      if (w_badDataOk) r_err <= 1'b1;
    end
  end

  // Head fields are forced to zero while the queue is empty so stale RAM contents never leak out
  assign bus.in_allowin    = w_allowin;
  assign bus.out_valid     = w_pop;
  assign bus.out_vaddr     = w_headValid ? w_headEntry[OFF_VADDR +: VADDR_W] : '0;
  assign bus.out_enable    = w_headValid ? w_headEntry[OFF_ENABLE +: INST_NUM] : '0;
  assign bus.out_has_exc   = w_headValid && w_headEntry[FTQ_OFF_EXC];
  assign bus.out_exc_code  = w_headValid ? w_headEntry[FTQ_OFF_CODE +: EXC_W] : '0;
  assign bus.out_is_refill = w_headValid && w_headEntry[FTQ_OFF_REFILL];
  assign bus.out_canceled  = w_headValid && (r_canceled[r_rdPtr] || bus.flush);
  assign bus.out_payload   = w_headValid ? w_headEntry[OFF_PAYLOAD +: PAYLOAD_W] : '0;
  assign bus.count         = r_count;
  assign bus.err_o         = r_err;

endmodule

// File: tb/tb_fetch_trace_queue.sv
// Directed self-checking bench for fetch_trace_queue: inputs change on the falling edge and
// outputs are checked 1 time unit later, well before the next rising edge.
module tb_fetch_trace_queue;
  import fetch_trace_queue_pkg::*;

  localparam int DEPTH     = 4;
  localparam int VADDR_W   = 32;
  localparam int INST_NUM  = 4;
  localparam int EXC_W     = 5;
  localparam int PAYLOAD_W = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fetch_trace_queue_if #(
    .DEPTH(DEPTH), .VADDR_W(VADDR_W), .INST_NUM(INST_NUM), .EXC_W(EXC_W), .PAYLOAD_W(PAYLOAD_W)
  ) bus ();

  fetch_trace_queue #(
    .DEPTH(DEPTH), .VADDR_W(VADDR_W), .INST_NUM(INST_NUM), .EXC_W(EXC_W), .PAYLOAD_W(PAYLOAD_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of stimulus at the falling edge; exception fields default to zero
  task automatic applyStimulus(input logic valid, input logic [31:0] vaddr, input logic dataOk,
                               input logic doFlush);
    @(negedge clk);
    bus.in_valid      = valid;
    bus.in_vaddr      = vaddr;
    bus.in_enable     = 4'hF;
    bus.in_has_exc    = 1'b0;
    bus.in_exc_code   = '0;
    bus.in_canceled   = 1'b0;
    bus.in_payload    = {8{vaddr}};
    bus.mmu_has_exc   = 1'b0;
    bus.mmu_exc_code  = '0;
    bus.mmu_is_refill = 1'b0;
    bus.inst_data_ok  = dataOk;
    bus.flush         = doFlush;
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.in_valid      = 1'b0;
    bus.in_vaddr      = '0;
    bus.in_enable     = '0;
    bus.in_has_exc    = 1'b0;
    bus.in_exc_code   = '0;
    bus.in_canceled   = 1'b0;
    bus.in_payload    = '0;
    bus.mmu_has_exc   = 1'b0;
    bus.mmu_exc_code  = '0;
    bus.mmu_is_refill = 1'b0;
    bus.inst_data_ok  = 1'b0;
    bus.flush         = 1'b0;

    #3;
    checkOutput("reset_count", 64'(bus.count), 64'd0);
    checkOutput("reset_allowin", 64'(bus.in_allowin), 64'd1);
    checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset_err", 64'(bus.err_o), 64'd0);
    checkOutput("reset_out_vaddr", 64'(bus.out_vaddr), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Fill to DEPTH with no bus responses
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h1000 + 32'(i * 16), 1'b0, 1'b0);
      checkOutput("fill_allowin", 64'(bus.in_allowin), 64'd1);
    end
    applyStimulus(1'b1, 32'h1050, 1'b0, 1'b0);
    checkOutput("full_count", 64'(bus.count), 64'd4);
    checkOutput("full_allowin", 64'(bus.in_allowin), 64'd0);
    checkOutput("full_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("full_head_vaddr", 64'(bus.out_vaddr), 64'h1000);

    // Full queue: push and pop in the same cycle
    applyStimulus(1'b1, 32'h1040, 1'b1, 1'b0);
    checkOutput("fullpp_count", 64'(bus.count), 64'd4);
    checkOutput("fullpp_allowin", 64'(bus.in_allowin), 64'd1);
    checkOutput("fullpp_out_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("fullpp_out_vaddr", 64'(bus.out_vaddr), 64'h1000);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      if (i == 0) begin
        checkOutput("drain_count", 64'(bus.count), 64'd4);
        checkOutput("drain_payload_lo", 64'(bus.out_payload[31:0]), 64'h1010);
        checkOutput("drain_payload_hi", 64'(bus.out_payload[255:224]), 64'h1010);
        checkOutput("drain_enable", 64'(bus.out_enable), 64'hF);
      end
      checkOutput("drain_out_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("drain_out_vaddr", 64'(bus.out_vaddr), 64'h1010 + 64'(i * 16));
      checkOutput("drain_canceled", 64'(bus.out_canceled), 64'd0);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("empty_count", 64'(bus.count), 64'd0);
    checkOutput("empty_out_vaddr", 64'(bus.out_vaddr), 64'd0);
    checkOutput("empty_err", 64'(bus.err_o), 64'd0);

    // MMU refill exception retires without a bus response
    applyStimulus(1'b1, 32'h2000, 1'b0, 1'b0);
    bus.mmu_has_exc   = 1'b1;
    bus.mmu_exc_code  = 5'd2;
    bus.mmu_is_refill = 1'b1;
    #1;
    checkOutput("exc_push_out_valid", 64'(bus.out_valid), 64'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("exc_out_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("exc_out_vaddr", 64'(bus.out_vaddr), 64'h2000);
    checkOutput("exc_has_exc", 64'(bus.out_has_exc), 64'd1);
    checkOutput("exc_code", 64'(bus.out_exc_code), 64'd2);
    checkOutput("exc_refill", 64'(bus.out_is_refill), 64'd1);

    // Upstream exception overrides the MMU code and refill flag
    applyStimulus(1'b1, 32'h2010, 1'b0, 1'b0);
    bus.in_has_exc    = 1'b1;
    bus.in_exc_code   = 5'd4;
    bus.mmu_has_exc   = 1'b1;
    bus.mmu_exc_code  = 5'd2;
    bus.mmu_is_refill = 1'b1;
    #1;
    checkOutput("upexc_count_before", 64'(bus.count), 64'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("upexc_out_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("upexc_code", 64'(bus.out_exc_code), 64'd4);
    checkOutput("upexc_refill", 64'(bus.out_is_refill), 64'd0);

    // A no-request entry behind a normal one waits for the older response
    applyStimulus(1'b1, 32'h3000, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h3010, 1'b0, 1'b0);
    bus.mmu_has_exc  = 1'b1;
    bus.mmu_exc_code = 5'd3;
    #1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("order_count", 64'(bus.count), 64'd2);
    checkOutput("order_wait_valid", 64'(bus.out_valid), 64'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("order_first_vaddr", 64'(bus.out_vaddr), 64'h3000);
    checkOutput("order_first_valid", 64'(bus.out_valid), 64'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("order_second_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("order_second_vaddr", 64'(bus.out_vaddr), 64'h3010);
    checkOutput("order_second_code", 64'(bus.out_exc_code), 64'd3);

    // Flush with a push cancels all four entries, which still drain in order
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h4000 + 32'(i * 16), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h4030, 1'b0, 1'b1);
    checkOutput("flush_count", 64'(bus.count), 64'd3);
    checkOutput("flush_head_canceled", 64'(bus.out_canceled), 64'd1);
    checkOutput("flush_out_valid", 64'(bus.out_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput("flush_drain_vaddr", 64'(bus.out_vaddr), 64'h4000 + 64'(i * 16));
      checkOutput("flush_drain_canceled", 64'(bus.out_canceled), 64'd1);
    end
    applyStimulus(1'b1, 32'h4040, 1'b0, 1'b0);
    checkOutput("postflush_count", 64'(bus.count), 64'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("postflush_vaddr", 64'(bus.out_vaddr), 64'h4040);
    checkOutput("postflush_canceled", 64'(bus.out_canceled), 64'd0);

    // Flush, push and pop together
    applyStimulus(1'b1, 32'h4800, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h4810, 1'b1, 1'b1);
    checkOutput("fpp_out_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("fpp_out_canceled", 64'(bus.out_canceled), 64'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("fpp_pushed_vaddr", 64'(bus.out_vaddr), 64'h4810);
    checkOutput("fpp_pushed_canceled", 64'(bus.out_canceled), 64'd1);

    // data_ok while empty is a sticky protocol error
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("perr_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("perr_not_yet", 64'(bus.err_o), 64'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("perr_err", 64'(bus.err_o), 64'd1);
    checkOutput("perr_count", 64'(bus.count), 64'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("perr_sticky", 64'(bus.err_o), 64'd1);

    // Asynchronous reset with entries in flight
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h5000 + 32'(i * 16), 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("areset_pre_count", 64'(bus.count), 64'd3);
    #1 rst = 1'b0;
    #1;
    checkOutput("areset_count", 64'(bus.count), 64'd0);
    checkOutput("areset_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("areset_allowin", 64'(bus.in_allowin), 64'd1);
    checkOutput("areset_err", 64'(bus.err_o), 64'd0);
    checkOutput("areset_out_vaddr", 64'(bus.out_vaddr), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("areset_after_count", 64'(bus.count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_trace_queue.md
Name: fetch_trace_queue

Overview:
- Parametrised successor to the single-entry fetch-to-decode trace register in the IF pipeline.
- Tracks up to DEPTH outstanding instruction-bus requests in issue order. Each entry holds the fetch VAddr, lane enables, exception information, a cancel flag and an opaque BPU payload (IJTC/RAS/PHT checkpoints and predictions, BTB info).
- Retires the head entry when its inst_data_ok arrives, or immediately if no bus request was issued for it.
- Sits between the address-translation stage and the instruction buffer.

Parameters:
- DEPTH, 4: queue entries; power of two, at least 2.
- VADDR_W, 32: virtual address width.
- INST_NUM, 4: instructions per fetch group (lane-enable width).
- EXC_W, 5: exception-code width.
- PAYLOAD_W, 256: width of the opaque BPU/BTB bundle, carried unmodified.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream has a fetch group this cycle.
- in_allowin  out  1  queue can accept this cycle.
- in_vaddr  in  VADDR_W  fetch-group VAddr.
- in_enable  in  INST_NUM  valid-lane mask.
- in_has_exc  in  1  upstream exception.
- in_exc_code  in  EXC_W  upstream exception code.
- in_canceled  in  1  group already canceled upstream.
- in_payload  in  PAYLOAD_W  BPU/BTB bundle.
- mmu_has_exc  in  1  MMU exception for in_vaddr.
- mmu_exc_code  in  EXC_W  MMU exception code.
- mmu_is_refill  in  1  MMU exception is a TLB refill.
- inst_data_ok  in  1  bus returns data for the oldest issued request.
- flush  in  1  branch-miss or exception cancel (BSC_needCancel | CP0_excOccur).
- out_valid  out  1  head entry retires this cycle.
- out_vaddr  out  VADDR_W  head VAddr.
- out_enable  out  INST_NUM  head lane mask.
- out_has_exc  out  1  head exception.
- out_exc_code  out  EXC_W  head exception code.
- out_is_refill  out  1  head refill flag.
- out_canceled  out  1  head must be discarded downstream.
- out_payload  out  PAYLOAD_W  head bundle.
- count  out  $clog2(DEPTH)+1  occupied entries.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (rst=0, async): all entries invalid; read and write pointers = 0; count = 0; err_o = 0. Outputs while empty: all out_* = 0, out_valid = 0, in_allowin = 1.

Push:
- push = in_valid && in_allowin.
- in_allowin = (count != DEPTH) || pop. Pushing while full is allowed only in a cycle where the head pops.

Stored entry fields:
- has_exc = in_has_exc | mmu_has_exc.
- exc_code = in_has_exc ? in_exc_code : mmu_exc_code (upstream takes priority).
- is_refill = !in_has_exc && mmu_is_refill.
- noreq = has_exc. No bus request is issued for an excepting group.
- canceled = in_canceled | flush.

Pop:
- out_valid = head_valid && (inst_data_ok || head.noreq).
- pop = out_valid. There is no downstream backpressure; the instruction buffer reserves space through its own allowin, which gates in_valid.
- Output latency is 0 from inst_data_ok: out_* present the head combinationally.

Flush:
- In the cycle flush=1, every valid entry (including the one being pushed) gets canceled=1 at the clock edge.
- Entries are not removed, because their bus responses must still drain.
- out_canceled reflects the registered flag OR flush, so a head popping during flush is already marked canceled.

Ordering:
- inst_data_ok always belongs to the oldest entry with noreq=0.
- Within the queue, noreq entries are only ever at positions reached in order. The head pops before any younger entry is considered; no reordering.

Protocol error:
- inst_data_ok while the queue is empty, or while head.noreq=1, sets err_o (sticky until reset).
- The strobe is ignored in both cases and the head is unaffected.

Count and pointers:
- count' = count + push - pop.
- Pointers are log2(DEPTH) bits and wrap naturally.

Simultaneous events:
- Push and pop in the same cycle: both take effect, count unchanged.
- Push into an empty queue: visible at the head next cycle, never in the same cycle.
- flush, push and pop together: the pushed entry is stored canceled and the popped entry leaves with out_canceled=1.

Reset mid-operation:
- All in-flight entries are lost immediately (async).
- The bus interface is reset by the same rst, so no stray data_ok follows.

Decomposition:
- Shared package / MyDefines additions: FTQ_DEPTH, FTQ_PAYLOAD_W, and the entry field layout (offsets of vaddr, enable, exc, code, refill, noreq, canceled).
- A single sub-module, ftq_entry_ram (DEPTH x entry-width register array, 1 write / 1 async read), is natural. Control (pointers, count, flags, error) stays in fetch_trace_queue.

Test Plan:
- Fill and drain: push 4 groups (vaddr 0x1000, 0x1010, 0x1020, 0x1030) with no data_ok → count=4, in_allowin=0. Then 4 data_ok cycles → out_vaddr in the same order, count returns to 0.
- Full with simultaneous push and pop: count=4, in_valid=1 and inst_data_ok=1 → in_allowin=1, pop 0x1000, push 0x1040, count stays 4.
- Exception bypass: push vaddr 0x2000 with mmu_has_exc=1, mmu_exc_code=2 (TLBL), mmu_is_refill=1 into an empty queue → next cycle out_valid=1 without data_ok, out_exc_code=2, out_is_refill=1. An upstream exception with in_exc_code=4 overrides the MMU code.
- Flush: 3 entries queued, flush=1 for one cycle with a push → all 4 entries drain on data_ok with out_canceled=1. A later push after the flush has out_canceled=0.
- Protocol error: inst_data_ok=1 while empty → err_o=1 and stays 1; count=0; no out_valid.
- Async reset: assert rst=0 mid-cycle with 3 entries queued → count=0, out_valid=0, in_allowin=1 before the next clk edge.
